// File: rtl/cmd_linear_wr_sched.sv
`default_nettype none
// ============================================================================
// Module : cmd_linear_wr_sched
// Splits one linear write request into encoder jobs. No job crosses a row or
// an external-buffer page.
// Rev    : 1.0
// ============================================================================
module cmd_linear_wr_sched #(
    parameter int ADDRESS_NUMBER = 15,
    parameter int COLADDR_NUMBER = 10,
    parameter int NUM_XFER_BITS  = 6,
    parameter int LEN_BITS       = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [2:0]                  req_bank,
    input  logic [ADDRESS_NUMBER-1:0]   req_row,
    input  logic [COLADDR_NUMBER-4:0]   req_col,
    input  logic [LEN_BITS-1:0]         req_len,
    output logic                        enc_start,
    output logic [2:0]                  enc_bank,
    output logic [ADDRESS_NUMBER-1:0]   enc_row,
    output logic [COLADDR_NUMBER-4:0]   enc_col,
    output logic [NUM_XFER_BITS-1:0]    enc_num128,
    output logic                        enc_skip_next_page,
    input  logic                        enc_done,
    output logic                        busy,
    output logic                        xfer_done
);

    localparam int CW = COLADDR_NUMBER - 3;
    localparam int NX = NUM_XFER_BITS;
    localparam int RW = LEN_BITS + 1;
    localparam logic [RW-1:0] BUF_PAGE = RW'(2**NX);
    localparam logic [RW-1:0] ROW_SIZE = RW'(2**CW);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_ISSUE = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [2:0]                bank_q, bank_d;
    logic [ADDRESS_NUMBER-1:0] row_q, row_d;
    logic [CW-1:0]             col_q, col_d;
    logic [RW-1:0]             rem_q, rem_d;
    logic [NX-1:0]             buf_ofs_q, buf_ofs_d;
    logic [NX:0]               chunk_q, chunk_d;
    logic                      enc_start_q, enc_start_d;
    logic [2:0]                enc_bank_q, enc_bank_d;
    logic [ADDRESS_NUMBER-1:0] enc_row_q, enc_row_d;
    logic [CW-1:0]             enc_col_q, enc_col_d;
    logic [NX-1:0]             enc_num_q, enc_num_d;
    logic                      enc_skip_q, enc_skip_d;
    logic                      req_ready_q, req_ready_d;
    logic                      busy_q, busy_d;
    logic                      xfer_done_q, xfer_done_d;

    logic [RW-1:0]             buf_room, col_room, min_a, chunk_w;
    logic [NX-1:0]             ofs_sum;
    logic [CW:0]               col_sum;

    always_comb begin
        buf_room = BUF_PAGE - RW'(buf_ofs_q);
        col_room = ROW_SIZE - RW'(col_q);
        min_a    = (rem_q < buf_room) ? rem_q : buf_room;
        chunk_w  = (min_a < col_room) ? min_a : col_room;
        ofs_sum  = buf_ofs_q + chunk_w[NX-1:0];
        col_sum  = (CW+1)'(col_q) + (CW+1)'(chunk_q);
    end

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        row_d       = row_q;
        col_d       = col_q;
        rem_d       = rem_q;
        buf_ofs_d   = buf_ofs_q;
        chunk_d     = chunk_q;
        enc_start_d = 1'b0;
        enc_bank_d  = enc_bank_q;
        enc_row_d   = enc_row_q;
        enc_col_d   = enc_col_q;
        enc_num_d   = enc_num_q;
        enc_skip_d  = enc_skip_q;
        xfer_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    bank_d    = req_bank;
                    row_d     = req_row;
                    col_d     = req_col;
                    // Zero length stands for the full 2^LEN_BITS range.
                    rem_d     = (req_len == '0) ? {1'b1, {LEN_BITS{1'b0}}}
                                                : {1'b0, req_len};
                    buf_ofs_d = '0;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                chunk_d     = chunk_w[NX:0];
                enc_bank_d  = bank_q;
                enc_row_d   = row_q;
                enc_col_d   = col_q;
                enc_num_d   = chunk_w[NX-1:0];
                enc_skip_d  = !((ofs_sum == '0) || (chunk_w == rem_q));
                enc_start_d = 1'b1;
                state_d     = S_ISSUE;
            end
            S_ISSUE: begin
                rem_d     = rem_q - RW'(chunk_q);
                buf_ofs_d = buf_ofs_q + chunk_q[NX-1:0];
                col_d     = col_sum[CW-1:0];
                // Column wrap moves to the next row, row wrap to the next bank.
                if (col_sum[CW]) begin
                    row_d = row_q + ADDRESS_NUMBER'(1);
                    if (&row_q)
                        bank_d = bank_q + 3'd1;
                end
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (enc_done) begin
                    if (rem_q == '0) begin
                        xfer_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Ready lags the return to idle by one cycle so it never overlaps xfer_done.
        req_ready_d = (state_d == S_IDLE) && !xfer_done_d;
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bank_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            rem_q       <= '0;
            buf_ofs_q   <= '0;
            chunk_q     <= '0;
            enc_start_q <= 1'b0;
            enc_bank_q  <= '0;
            enc_row_q   <= '0;
            enc_col_q   <= '0;
            enc_num_q   <= '0;
            enc_skip_q  <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            xfer_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rem_q       <= rem_d;
            buf_ofs_q   <= buf_ofs_d;
            chunk_q     <= chunk_d;
            enc_start_q <= enc_start_d;
            enc_bank_q  <= enc_bank_d;
            enc_row_q   <= enc_row_d;
            enc_col_q   <= enc_col_d;
            enc_num_q   <= enc_num_d;
            enc_skip_q  <= enc_skip_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            xfer_done_q <= xfer_done_d;
        end
    end

    assign req_ready          = req_ready_q;
    assign enc_start          = enc_start_q;
    assign enc_bank           = enc_bank_q;
    assign enc_row            = enc_row_q;
    assign enc_col            = enc_col_q;
    assign enc_num128         = enc_num_q;
    assign enc_skip_next_page = enc_skip_q;
    assign busy               = busy_q;
    assign xfer_done          = xfer_done_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_linear_wr_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_cmd_linear_wr_sched
// Directed bench with an expected-job scoreboard for cmd_linear_wr_sched.
// Rev    : 1.0
// ============================================================================
module tb_cmd_linear_wr_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_bank;
    logic [14:0] req_row;
    logic [6:0]  req_col;
    logic [15:0] req_len;
    logic        enc_start;
    logic [2:0]  enc_bank;
    logic [14:0] enc_row;
    logic [6:0]  enc_col;
    logic [5:0]  enc_num128;
    logic        enc_skip_next_page;
    logic        enc_done;
    logic        busy;
    logic        xfer_done;

    cmd_linear_wr_sched #(
        .ADDRESS_NUMBER(15),
        .COLADDR_NUMBER(10),
        .NUM_XFER_BITS (6),
        .LEN_BITS      (16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_bank          (req_bank),
        .req_row           (req_row),
        .req_col           (req_col),
        .req_len           (req_len),
        .enc_start         (enc_start),
        .enc_bank          (enc_bank),
        .enc_row           (enc_row),
        .enc_col           (enc_col),
        .enc_num128        (enc_num128),
        .enc_skip_next_page(enc_skip_next_page),
        .enc_done          (enc_done),
        .busy              (busy),
        .xfer_done         (xfer_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  bank;
        logic [14:0] row;
        logic [6:0]  col;
        logic [5:0]  num;
        logic        skip;
    } job_t;

    job_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_start  = 0;
    int   n_xfer   = 0;

    always @(posedge clk) begin
        if (enc_start === 1'b1) n_start <= n_start + 1;
        if (xfer_done === 1'b1) n_xfer  <= n_xfer + 1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_job(input int b, input int r, input int c, input int n, input bit s);
        job_t j;
        j.bank = 3'(b);
        j.row  = 15'(r);
        j.col  = 7'(c);
        j.num  = 6'(n);
        j.skip = s;
        exp_q.push_back(j);
    endtask

    // Reference split: 128 bursts per row, 64-burst buffer pages.
    task automatic model_push(input int b, input int r, input int c, input int len);
        int rem = (len == 0) ? 65536 : len;
        int bo  = 0;
        int ch;
        while (rem > 0) begin
            ch = rem;
            if (64 - bo < ch)  ch = 64 - bo;
            if (128 - c < ch)  ch = 128 - c;
            push_job(b, r, c, ch % 64, !(((bo + ch) % 64 == 0) || ch == rem));
            rem -= ch;
            bo   = (bo + ch) % 64;
            c   += ch;
            if (c == 128) begin
                c = 0;
                r = (r + 1) % 32768;
                if (r == 0) b = (b + 1) % 8;
            end
        end
    endtask

    task automatic send_req(input int b, input int r, input int c, input int len);
        int i = 0;
        while (req_ready !== 1'b1 && i < 20) begin @(negedge clk); i++; end
        check("req_ready_before_send", req_ready, 1);
        req_valid = 1'b1;
        req_bank  = 3'(b);
        req_row   = 15'(r);
        req_col   = 7'(c);
        req_len   = 16'(len);
        @(negedge clk);
        req_valid = 1'b0;
        check("busy_after_accept", busy, 1);
        check("ready_low_after_accept", req_ready, 0);
    endtask

    task automatic do_job(input int delay, input bit spur_issue);
        int   i = 0;
        job_t e;
        while (enc_start !== 1'b1 && i < 20) begin @(negedge clk); i++; end
        check("start_latency", i, 1);
        check("scoreboard_nonempty", (exp_q.size() != 0), 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check("job_bank", enc_bank, e.bank);
        check("job_row", enc_row, e.row);
        check("job_col", enc_col, e.col);
        check("job_num128", enc_num128, e.num);
        check("job_skip", enc_skip_next_page, e.skip);
        if (spur_issue) enc_done = 1'b1;
        @(negedge clk);
        enc_done = 1'b0;
        check("start_single_cycle", enc_start, 0);
        repeat (delay) @(negedge clk);
        check("num128_held_in_wait", enc_num128, e.num);
        check("start_low_in_wait", enc_start, 0);
        enc_done = 1'b1;
        @(negedge clk);
        enc_done = 1'b0;
    endtask

    task automatic finish_chk();
        check("xfer_done_pulse", xfer_done, 1);
        check("busy_low_at_xfer", busy, 0);
        check("ready_lags_xfer", req_ready, 0);
        @(negedge clk);
        check("xfer_done_single", xfer_done, 0);
        check("ready_after_xfer", req_ready, 1);
    endtask

    initial begin
        int s0, x0, na;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_bank  = '0;
        req_row   = '0;
        req_col   = '0;
        req_len   = '0;
        enc_done  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", req_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_start", enc_start, 0);
        check("reset_num128", enc_num128, 0);
        check("reset_xfer", xfer_done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", req_ready, 1);

        // Single job
        s0 = n_start; x0 = n_xfer;
        push_job(0, 0, 0, 5, 1'b0);
        send_req(0, 0, 0, 5);
        do_job(0, 1'b0);
        finish_chk();
        check("single_start_count", n_start - s0, 1);
        check("single_xfer_count", n_xfer - x0, 1);

        // Buffer-page split
        push_job(0, 0, 0, 0, 1'b0);
        push_job(0, 0, 64, 36, 1'b0);
        send_req(0, 0, 0, 100);
        do_job(1, 1'b0);
        check("no_xfer_mid_request", xfer_done, 0);
        do_job(10, 1'b0);
        finish_chk();

        // Row crossing, with a spurious done during ISSUE
        s0 = n_start;
        push_job(0, 7, 120, 8, 1'b1);
        push_job(0, 8, 0, 12, 1'b0);
        send_req(0, 7, 120, 20);
        do_job(0, 1'b1);
        do_job(0, 1'b0);
        finish_chk();
        check("row_cross_start_count", n_start - s0, 2);

        // Bank carry
        push_job(2, 15'h7FFF, 124, 4, 1'b1);
        push_job(3, 0, 0, 4, 1'b0);
        send_req(2, 32'h7FFF, 124, 8);
        do_job(2, 1'b0);
        do_job(0, 1'b0);
        finish_chk();

        // Spurious done in IDLE
        s0 = n_start;
        enc_done = 1'b1;
        repeat (2) @(negedge clk);
        enc_done = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_done_no_start", n_start - s0, 0);
        check("idle_done_not_busy", busy, 0);

        // Second request held during a longer multi-job request
        model_push(5, 3, 100, 300);
        na = exp_q.size();
        push_job(1, 16, 0, 0, 1'b0);
        send_req(5, 3, 100, 300);
        req_valid = 1'b1;
        req_bank  = 3'd1;
        req_row   = 15'd16;
        req_col   = 7'd0;
        req_len   = 16'd64;
        for (int k = 0; k < na; k++) begin
            check("held_req_not_taken", req_ready, 0);
            do_job(k % 3, 1'b0);
        end
        finish_chk();
        @(negedge clk);
        check("held_req_accepted", busy, 1);
        req_valid = 1'b0;
        do_job(2, 1'b0);
        finish_chk();

        // Reset in WAIT
        s0 = n_start; x0 = n_xfer;
        send_req(0, 0, 0, 5);
        @(negedge clk);
        check("pre_reset_start", enc_start, 1);
        check("pre_reset_num128", enc_num128, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_start", enc_start, 0);
        check("arst_num128", enc_num128, 0);
        check("arst_col_row_bank", {enc_bank, enc_row, enc_col}, 0);
        check("arst_skip", enc_skip_next_page, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", req_ready, 0);
        check("arst_xfer", xfer_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = n_start; x0 = n_xfer;
        @(negedge clk);
        check("post_reset_ready", req_ready, 1);
        check("post_reset_busy", busy, 0);
        enc_done = 1'b1;
        @(negedge clk);
        enc_done = 1'b0;
        repeat (5) @(negedge clk);
        check("post_reset_no_start", n_start - s0, 0);
        check("post_reset_no_xfer", n_xfer - x0, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmd_linear_wr_sched.md
Name: cmd_linear_wr_sched

Overview:
- Upstream stage of the linear-write command encoder. Accepts one linear write request (bank, row, start column, total length in 128-bit bursts).
- Splits the request into encoder jobs. No job crosses a memory row (page) boundary or an external-buffer page (2^NUM_XFER_BITS bursts).
- Drives the encoder's start/bank/row/col/num128/skip_next_page inputs and waits for its done pulse before issuing the next job.

Parameters:
- ADDRESS_NUMBER, 15, row address width.
- COLADDR_NUMBER, 10, column address width; one row holds 2^(COLADDR_NUMBER-3) bursts.
- NUM_XFER_BITS, 6, encoder length field width; buffer page = 2^NUM_XFER_BITS bursts.
- LEN_BITS, 16, width of the total request length.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_bank  in  3  start bank
- req_row  in  ADDRESS_NUMBER  start row
- req_col  in  COLADDR_NUMBER-3  start column in bursts
- req_len  in  LEN_BITS  total bursts; 0 means 2^LEN_BITS
- enc_start  out  1  one-cycle start pulse to the encoder
- enc_bank  out  3  bank for the current job
- enc_row  out  ADDRESS_NUMBER  row for the current job
- enc_col  out  COLADDR_NUMBER-3  start column for the current job
- enc_num128  out  NUM_XFER_BITS  job length; 0 encodes 2^NUM_XFER_BITS
- enc_skip_next_page  out  1  1 = do not advance the external buffer page after this job
- enc_done  in  1  encoder finished the current job
- busy  out  1  request in progress
- xfer_done  out  1  one-cycle pulse after the last job's enc_done

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE. req_ready=1 only after reset release. All other outputs are 0, and all internal counters (rem, buf_ofs) are 0.
- FSM states: IDLE, CALC, ISSUE, WAIT.
  - IDLE: req_ready=1. On handshake, latch bank/row/col, rem = req_len (0 → 2^LEN_BITS, held in LEN_BITS+1 bits), buf_ofs=0; go to CALC.
  - CALC (1 cycle): compute chunk = min(rem, 2^NUM_XFER_BITS − buf_ofs, 2^(COLADDR_NUMBER-3) − col). Register enc_bank/row/col, enc_num128 = chunk mod 2^NUM_XFER_BITS, and enc_skip_next_page = !(((buf_ofs+chunk) mod 2^NUM_XFER_BITS == 0) || chunk == rem). Go to ISSUE.
  - ISSUE (1 cycle): enc_start=1. Then update rem −= chunk, buf_ofs = (buf_ofs+chunk) mod 2^NUM_XFER_BITS, col += chunk. If col wraps to 0: row += 1. If row also wraps to 0: bank += 1 (mod 8). Go to WAIT.
  - WAIT: hold all enc_* values except enc_start. On enc_done: if rem==0, pulse xfer_done and go to IDLE; else go to CALC.
- Latency: request handshake at cycle N → enc_start at N+2. enc_done at cycle M → next enc_start at M+2, or xfer_done at M+1.
- busy = (state != IDLE). req_ready = (state == IDLE) and reset released. xfer_done and the IDLE return happen in the same cycle; req_ready rises the cycle after xfer_done.
- enc_done outside WAIT is ignored; no error flag. enc_done during ISSUE is ignored.
- req_valid while busy is not accepted; the requester holds the request.
- enc_start is never asserted twice without an intervening enc_done.
- All arithmetic is unsigned. chunk is always ≥1 and ≤2^NUM_XFER_BITS.
- Reset mid-operation aborts immediately. No enc_start or xfer_done is produced after reset release until a new request is accepted.

Test Plan:
- Single job: col=0, len=5 → one enc_start with num128=5, col=0, skip=0; enc_done → xfer_done 1 cycle later; exactly one start pulse.
- Buffer-page split: col=0, len=100 → jobs (col 0, num128=0 i.e. 64, skip=0) then (col 64, num128=36, skip=0); xfer_done after the second enc_done.
- Row crossing: row=7, col=120, len=20 → jobs (row 7, col 120, len 8, skip=1), then (row 8, col 0, len 12, skip=0).
- Bank carry: bank=2, row=0x7FFF, col=124, len=8 → second job has bank=3, row=0, col=0, len 4.
- Handshake timing: enc_done delayed by 0/1/10 cycles; spurious enc_done in IDLE and ISSUE → no extra start; second req_valid held during busy is accepted only after xfer_done.
- Reset mid-WAIT: rst_n low for 1 cycle → all outputs 0 at once, req_ready=1 after release; a subsequent enc_done produces nothing.
